ref_rd_ctrl: RTL

REF_RD_CTRL -- requirements
Module: ref_rd_ctrl

---
 rtl/ref_rd_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ref_rd_ctrl.sv
// Reference-memory read controller: issues bank reads (8-row or single-row sweep),
// buffers the fixed-latency returns in a 4-deep FIFO and streams beats to a consumer.
module ref_rd_ctrl (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [6:0]    base_addr,
    input  logic [6:0]    num_addr,
    output logic [6:0]    rd_address,
    output logic          rd8R_en,
    output logic [3:0]    rdR_sel,
    input  logic [2047:0] ref_8R_32,
    input  logic          Oda8R_va,
    input  logic          da1R_va,
    output logic [2047:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [6:0]    addr_q, addr_d;
    logic [6:0]    rem_q, rem_d;
    logic [3:0]    row_q, row_d;
    logic [1:0]    infl_q, infl_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    wr_q, rd_q;
    logic [2047:0] mem_q [4];

    logic [6:0]    num_clamped;
    logic [6:0]    addr_next;
    logic [3:0]    occupancy;
    logic          issue;
    logic          last;
    logic          ret_va;
    logic          push;
    logic          pop;
    logic [2047:0] ret_data;

    assign num_clamped = (num_addr > 7'd96) ? 7'd96 : num_addr;
    assign addr_next   = (addr_q >= 7'd95) ? 7'd0 : addr_q + 7'd1;
    // Reserve a FIFO slot for every read still in flight so returns never overflow.
    assign occupancy   = {1'b0, cnt_q} + {2'b00, infl_q};
    assign issue       = (state_q == ISSUE) && (occupancy < 4'd4);
    assign last        = mode_q ? ((rem_q == 7'd1) && (row_q == 4'd8)) : (rem_q == 7'd1);
    assign ret_va      = mode_q ? da1R_va : Oda8R_va;
    assign push        = ret_va && (infl_q != 2'd0);
    assign ret_data    = mode_q ? {1792'd0, ref_8R_32[255:0]} : ref_8R_32;
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            row_q   <= '0;
            infl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            row_q   <= row_d;
            infl_q  <= infl_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    addr_d  = base_addr;
                    rem_d   = num_clamped;
                    row_d   = 4'd1;
                    state_d = (num_clamped == 7'd0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (mode_q && (row_q != 4'd8)) begin
                        row_d = row_q + 4'd1;
                    end else begin
                        row_d  = 4'd1;
                        addr_d = addr_next;
                        rem_d  = rem_q - 7'd1;
                    end
                    if (last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((infl_q == 2'd0) && (cnt_q == 3'd0)) begin
                    state_d = FIN;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        infl_d = infl_q;
        unique case ({issue, push})
            2'b10:   infl_d = infl_q + 2'd1;
            2'b01:   infl_d = infl_q - 2'd1;
            default: infl_d = infl_q;
        endcase
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= ret_data;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
        end
    end

    always_comb begin
        rd_address = addr_q;
        rd8R_en    = issue;
        rdR_sel    = (issue && mode_q) ? row_q : 4'd0;
        out_valid  = (cnt_q != 3'd0);
        out_data   = out_valid ? mem_q[rd_q] : '0;
        busy       = (state_q != IDLE);
        done       = (state_q == FIN);
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt_q == 3'd4)));

endmodule
